// File: rtl/max7000_pkg.sv
// max7000_pkg: shared MAX7000 LAB counts, macrocell config layout and term role indices
package max7000_pkg;

    localparam int PIA_COUNT       = 36;
    localparam int EXPANDER_COUNT  = 16;
    localparam int MACROCELL_COUNT = 16;
    localparam int TERMS           = 5;
    localparam int LAB_SIGNALS     = 2 * PIA_COUNT + EXPANDER_COUNT;

    localparam int CFG_XOR_INVERT      = 0;
    localparam int CFG_REGISTER_BYPASS = 1;
    localparam int CFG_TOGGLE_MODE     = 2;
    localparam int CFG_CE_FROM_PT      = 3;
    localparam int CFG_CLEAR_FROM_PT   = 4;
    localparam int CFG_EXPANDER_EN     = 5;
    localparam int CFG_WIDTH           = 6;

    localparam int PT_CE       = 1;
    localparam int PT_CLEAR    = 2;
    localparam int PT_EXPANDER = 4;

    // Field order matches the config bit indices above, MSB first
    typedef struct packed {
        logic expander_en;
        logic clear_from_pt;
        logic ce_from_pt;
        logic toggle_mode;
        logic register_bypass;
        logic xor_invert;
    } cfg_t;

endpackage

// File: rtl/max7000_macrocell.sv
// max7000_macrocell: one macrocell with product terms, role muxing, sum, xor, register and bypass
module max7000_macrocell
    import max7000_pkg::*;
#(
    parameter int P = TERMS,
    parameter int L = LAB_SIGNALS
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [L-1:0] lab_signals,
    input  logic [P*L-1:0] pt_mask,
    input  cfg_t         cfg,
    output logic         result,
    output logic         expander
);

    logic [P-1:0] pt;
    logic [P-1:0] claimed;
    logic         d;
    logic         ce;
    logic         clear;
    logic         q;

    // An all-zero mask is an unprogrammed term and must read as 0, not as an empty AND
    for (genvar k = 0; k < P; k++) begin : g_pt
        assign pt[k] = (|pt_mask[k*L +: L]) && (&(lab_signals | ~pt_mask[k*L +: L]));
    end

    // Terms claimed for control or expander duty drop out of the sum
    always_comb begin
        claimed              = '0;
        claimed[PT_CE]       = cfg.ce_from_pt;
        claimed[PT_CLEAR]    = cfg.clear_from_pt;
        claimed[PT_EXPANDER] = cfg.expander_en;
        d                    = (|(pt & ~claimed)) ^ cfg.xor_invert;
        ce                   = cfg.ce_from_pt ? pt[PT_CE] : 1'b1;
        clear                = cfg.clear_from_pt && pt[PT_CLEAR];
        expander             = cfg.expander_en ? ~pt[PT_EXPANDER] : 1'b1;
        result               = cfg.register_bypass ? d : q;
    end

    // Macrocell register: reset, then clear, then enabled load or toggle
    always_ff @(posedge clock) begin
        if (reset)
            q <= 1'b0;
        else if (clear)
            q <= 1'b0;
        else if (ce)
            q <= cfg.toggle_mode ? (q ^ d) : d;
    end

endmodule

// File: rtl/lab_macrocell_array.sv
// lab_macrocell_array: the macrocells of one LAB, sliced from the shared mask and config buses
module lab_macrocell_array
    import max7000_pkg::*;
#(
    parameter int macrocell_count             = MACROCELL_COUNT,
    parameter int product_terms_per_macrocell = TERMS,
    parameter int lab_signal_count            = LAB_SIGNALS
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [lab_signal_count-1:0] lab_signals,
    input  logic [macrocell_count*product_terms_per_macrocell*lab_signal_count-1:0] pt_mask,
    input  logic [macrocell_count*CFG_WIDTH-1:0] macrocell_config,
    output logic [macrocell_count-1:0]  macrocell_outputs,
    output logic [macrocell_count-1:0]  expander_product_terms
);

    localparam int SLICE = product_terms_per_macrocell * lab_signal_count;

    for (genvar m = 0; m < macrocell_count; m++) begin : g_mc
        max7000_macrocell #(
            .P(product_terms_per_macrocell),
            .L(lab_signal_count)
        ) u_mc (
            .clock      (clock),
            .reset      (reset),
            .lab_signals(lab_signals),
            .pt_mask    (pt_mask[m*SLICE +: SLICE]),
            .cfg        (cfg_t'(macrocell_config[m*CFG_WIDTH +: CFG_WIDTH])),
            .result     (macrocell_outputs[m]),
            .expander   (expander_product_terms[m])
        );
    end

endmodule

// File: tb/tb_lab_macrocell_array.sv
// tb_lab_macrocell_array: scoreboard bench for the LAB macrocell array
module tb_lab_macrocell_array;

    localparam int MC = 16;
    localparam int P  = 5;
    localparam int L  = 88;

    logic              clock = 1'b0;
    logic              reset;
    logic [L-1:0]      lab_signals;
    logic [MC*P*L-1:0] pt_mask;
    logic [MC*6-1:0]   macrocell_config;
    logic [MC-1:0]     macrocell_outputs;
    logic [MC-1:0]     expander_product_terms;

    typedef struct {
        string       tag;
        bit          sel;
        logic [15:0] care;
        logic [15:0] exp;
    } entry_t;

    entry_t sb[$];
    int     total = 0;
    int     bad   = 0;

    lab_macrocell_array dut (
        .clock                 (clock),
        .reset                 (reset),
        .lab_signals           (lab_signals),
        .pt_mask               (pt_mask),
        .macrocell_config      (macrocell_config),
        .macrocell_outputs     (macrocell_outputs),
        .expander_product_terms(expander_product_terms)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_vec(input string tag, input bit sel, input logic [15:0] exp);
        sb.push_back('{tag, sel, 16'hFFFF, exp});
    endtask

    task automatic push_bit(input string tag, input bit sel, input int idx, input logic val);
        sb.push_back('{tag, sel, 16'(1) << idx, 16'(val) << idx});
    endtask

    task automatic drain();
        entry_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, (e.sel ? expander_product_terms : macrocell_outputs) & e.care, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_pt(input int m, input int k, input int b);
        pt_mask[((m*P)+k)*L +: L] = (b < 0) ? '0 : (L'(1) << b);
    endtask

    task automatic set_cfg(input int m, input logic [5:0] c);
        macrocell_config[m*6 +: 6] = c;
    endtask

    initial begin
        reset            = 1'b1;
        lab_signals      = '1;
        pt_mask          = '0;
        macrocell_config = '0;
        for (int m = 0; m < MC; m++) set_pt(m, 0, 87);
        tick();
        push_vec("rst_out_1", 0, 16'h0000);
        push_vec("rst_exp", 1, 16'hFFFF);
        drain();
        tick();
        push_vec("rst_out_2", 0, 16'h0000);
        drain();
        reset = 1'b0;
        tick();
        push_vec("all_load", 0, 16'hFFFF);
        drain();
        pt_mask = '0;
        tick();
        push_vec("all_clear", 0, 16'h0000);
        drain();
        // cell 0 plain D register
        set_pt(0, 0, 87);
        lab_signals[87] = 1'b0;
        tick();
        push_bit("d_low", 0, 0, 1'b0);
        drain();
        lab_signals[87] = 1'b1;
        settle();
        push_bit("d_same_cycle", 0, 0, 1'b0);
        drain();
        tick();
        push_bit("d_next_edge", 0, 0, 1'b1);
        drain();
        set_pt(0, 0, -1);
        tick();
        push_bit("d_unprogrammed", 0, 0, 1'b0);
        drain();
        // cell 3 bypass with inversion
        set_cfg(3, 6'b000011);
        settle();
        push_bit("byp_inv_empty", 0, 3, 1'b1);
        drain();
        set_pt(3, 0, 87);
        settle();
        push_bit("byp_inv_hit", 0, 3, 1'b0);
        drain();
        lab_signals[87] = 1'b0;
        settle();
        push_bit("byp_inv_miss", 0, 3, 1'b1);
        drain();
        lab_signals[87] = 1'b1;
        set_cfg(3, 6'b000000);
        set_pt(3, 0, -1);
        tick();
        // cell 5 clock enable and clear from terms
        set_cfg(5, 6'b011000);
        set_pt(5, 0, 0);
        set_pt(5, 1, 1);
        set_pt(5, 2, 2);
        lab_signals[2:0] = 3'b011;
        settle();
        push_bit("ce_before_edge", 0, 5, 1'b0);
        drain();
        tick();
        push_bit("ce_load", 0, 5, 1'b1);
        drain();
        lab_signals[2] = 1'b1;
        tick();
        push_bit("clear_wins", 0, 5, 1'b0);
        drain();
        lab_signals[2] = 1'b0;
        tick();
        push_bit("ce_reload", 0, 5, 1'b1);
        drain();
        lab_signals[1:0] = 2'b00;
        tick();
        push_bit("ce_hold", 0, 5, 1'b1);
        drain();
        lab_signals[2] = 1'b1;
        tick();
        push_bit("clear_no_ce", 0, 5, 1'b0);
        drain();
        lab_signals[2:0] = 3'b111;
        set_cfg(5, 6'b000000);
        for (int k = 0; k < 3; k++) set_pt(5, k, -1);
        tick();
        push_bit("ce_cleanup", 0, 5, 1'b0);
        drain();
        // cell 7 toggle, interrupted by reset
        set_cfg(7, 6'b000100);
        set_pt(7, 0, 3);
        tick();
        push_bit("tog_1", 0, 7, 1'b1);
        drain();
        tick();
        push_bit("tog_2", 0, 7, 1'b0);
        drain();
        tick();
        push_bit("tog_3", 0, 7, 1'b1);
        drain();
        reset = 1'b1;
        tick();
        push_bit("tog_reset", 0, 7, 1'b0);
        drain();
        tick();
        push_bit("tog_reset_hold", 0, 7, 1'b0);
        drain();
        reset = 1'b0;
        tick();
        push_bit("tog_resume", 0, 7, 1'b1);
        drain();
        set_cfg(7, 6'b000000);
        set_pt(7, 0, -1);
        tick();
        // cell 9 expander term
        set_cfg(9, 6'b100000);
        set_pt(9, 4, 87);
        settle();
        push_bit("exp_active", 1, 9, 1'b0);
        push_bit("exp_no_sum", 0, 9, 1'b0);
        drain();
        tick();
        push_bit("exp_no_sum_reg", 0, 9, 1'b0);
        drain();
        lab_signals[87] = 1'b0;
        settle();
        push_bit("exp_miss", 1, 9, 1'b1);
        drain();
        lab_signals[87] = 1'b1;
        set_cfg(9, 6'b000000);
        settle();
        push_bit("exp_disabled", 1, 9, 1'b1);
        push_bit("exp_sum_pending", 0, 9, 1'b0);
        drain();
        tick();
        push_bit("exp_sum_reg", 0, 9, 1'b1);
        push_vec("others_idle", 0, 16'h0200);
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
